lane_deskew_ctrl: RTL and testbench



---
 rtl/lane_deskew_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lane_deskew_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lane_deskew_ctrl.sv
// Lane deskew controller: measures alignment-marker arrival skew over the active lanes
// and programs per-lane delay_select so every lane lines up with the latest arrival.
// Define DESKEW_SKEW_STAT_EN to add the measured_skew status output.
module lane_deskew_ctrl #(
    parameter int LANES          = 16,
    parameter int DELAY_WIDTH    = 3,
    parameter int MAX_SKEW       = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         RX_CLK,
    input  logic                         rst,
    input  logic                         Soft_RST_blocks,
    input  logic                         EN_LTSSM,
    input  logic                         GEN,
    input  logic                         deskew_start,
    input  logic [LANES-1:0]             lane_mask,
    input  logic [LANES-1:0]             marker_detect,
    output logic [LANES*DELAY_WIDTH-1:0] delay_select,
    output logic                         deskew_busy,
    output logic                         deskew_done,
    output logic                         deskew_error
`ifdef DESKEW_SKEW_STAT_EN
    ,
    output logic [DELAY_WIDTH-1:0]       measured_skew
`endif
);

    localparam int CW = DELAY_WIDTH + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] MAX_SKEW_C = CW'(MAX_SKEW);
    localparam logic [TW-1:0] TIMEOUT_C  = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        MEASURE = 3'd2,
        LOCKED  = 3'd3,
        ERROR   = 3'd4
    } state_t;

    state_t                       state_q;
    logic [LANES-1:0]             mask_q;
    logic [LANES-1:0]             seen_q;
    logic [CW-1:0]                arrival_q [LANES];
    logic [CW-1:0]                cnt_q;
    logic [TW-1:0]                tmo_q;
    logic [LANES*DELAY_WIDTH-1:0] delay_q;
    logic                         busy_q;
    logic                         done_q;
    logic                         error_q;
    logic [DELAY_WIDTH-1:0]       skew_q;

    logic [LANES-1:0]             hit_s;
    logic [LANES-1:0]             seen_d;
    logic                         all_seen_s;
    logic [CW-1:0]                arrival_d [LANES];
    logic [LANES*DELAY_WIDTH-1:0] delay_d;

    // First-arrival bookkeeping and the delay each lane would get if this cycle completes the set.
    // cnt_q is 0 throughout ARMED, so first hits record arrival 0 with the same logic.
    always_comb begin
        hit_s      = marker_detect & mask_q & ~seen_q;
        seen_d     = seen_q | hit_s;
        all_seen_s = &(seen_d | ~mask_q);
        delay_d    = '0;
        for (int i = 0; i < LANES; i++) begin
            arrival_d[i] = hit_s[i] ? cnt_q : arrival_q[i];
            if (mask_q[i]) begin
                delay_d[i*DELAY_WIDTH +: DELAY_WIDTH] = DELAY_WIDTH'(cnt_q - arrival_d[i]);
            end else begin
                delay_d[i*DELAY_WIDTH +: DELAY_WIDTH] = '0;
            end
        end
    end

    // Deskew FSM with registered status and delay outputs.
    always_ff @(posedge RX_CLK or negedge rst) begin
        if (!rst || Soft_RST_blocks) begin
            state_q <= IDLE;
            mask_q  <= '0;
            seen_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            delay_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            skew_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                arrival_q[i] <= '0;
            end
        end else if (!EN_LTSSM || !GEN) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, LOCKED, ERROR: begin
                    if (deskew_start) begin
                        state_q <= ARMED;
                        mask_q  <= lane_mask;
                        seen_q  <= '0;
                        cnt_q   <= '0;
                        tmo_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        error_q <= 1'b0;
                        for (int i = 0; i < LANES; i++) begin
                            arrival_q[i] <= '0;
                        end
                    end
                end
                ARMED: begin
                    if (mask_q == '0) begin
                        state_q <= LOCKED;
                        delay_q <= '0;
                        skew_q  <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (|hit_s) begin
                        seen_q    <= seen_d;
                        arrival_q <= arrival_d;
                        cnt_q     <= CW'(1);
                        if (all_seen_s) begin
                            state_q <= LOCKED;
                            delay_q <= delay_d;
                            skew_q  <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= MEASURE;
                        end
                    end else if (tmo_q >= TIMEOUT_C) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                MEASURE: begin
                    seen_q    <= seen_d;
                    arrival_q <= arrival_d;
                    cnt_q     <= cnt_q + CW'(1);
                    if (all_seen_s) begin
                        // The earliest masked arrival is always 0, so the skew equals the latest arrival.
                        state_q <= LOCKED;
                        delay_q <= delay_d;
                        skew_q  <= DELAY_WIDTH'(cnt_q);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q >= MAX_SKEW_C) begin
                        state_q <= ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    error_q <= 1'b0;
                end
            endcase
        end
    end

    assign delay_select = delay_q;
    assign deskew_busy  = busy_q;
    assign deskew_done  = done_q;
    assign deskew_error = error_q;

`ifdef DESKEW_SKEW_STAT_EN
    assign measured_skew = skew_q;
`else
    logic unused_skew_s;
    assign unused_skew_s = ^skew_q;
`endif

endmodule

// File: tb/tb_lane_deskew_ctrl.sv
// Directed bench for lane_deskew_ctrl (4 lanes) with an expected-result scoreboard queue.
module tb_lane_deskew_ctrl;

    localparam int LANES = 4;
    localparam int DW    = 3;

    logic                  clk;
    logic                  rst;
    logic                  soft_rst;
    logic                  en_ltssm;
    logic                  gen;
    logic                  start;
    logic [LANES-1:0]      lane_mask;
    logic [LANES-1:0]      marker;
    logic [LANES*DW-1:0]   delay_select;
    logic                  busy;
    logic                  done;
    logic                  error;
`ifdef DESKEW_SKEW_STAT_EN
    logic [DW-1:0]         measured_skew;
`endif

    typedef struct {
        logic [LANES*DW-1:0] dly;
        logic                done;
        logic                err;
        logic [DW-1:0]       skew;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    lane_deskew_ctrl #(
        .LANES(LANES), .DELAY_WIDTH(DW), .MAX_SKEW(6), .TIMEOUT_CYCLES(255)
    ) dut (
        .RX_CLK          (clk),
        .rst             (rst),
        .Soft_RST_blocks (soft_rst),
        .EN_LTSSM        (en_ltssm),
        .GEN             (gen),
        .deskew_start    (start),
        .lane_mask       (lane_mask),
        .marker_detect   (marker),
        .delay_select    (delay_select),
        .deskew_busy     (busy),
        .deskew_done     (done),
        .deskew_error    (error)
`ifdef DESKEW_SKEW_STAT_EN
        ,
        .measured_skew   (measured_skew)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [LANES*DW-1:0] d, input logic dn, input logic er,
                        input logic [DW-1:0] sk);
        exp_t e;
        e.dly  = d;
        e.done = dn;
        e.err  = er;
        e.skew = sk;
        exp_q.push_back(e);
    endtask

    // Wait at most 'budget' further cycles for done/error, then compare against the queue head.
    task automatic wait_result(input string tag, input int budget);
        exp_t e;
        int   n;
        n = 0;
        while (!(done || error) && n < budget) begin
            tick();
            n++;
        end
        e = exp_q.pop_front();
        chk({tag, "_done"},  32'(done),         32'(e.done));
        chk({tag, "_error"}, 32'(error),        32'(e.err));
        chk({tag, "_delay"}, 32'(delay_select), 32'(e.dly));
        chk({tag, "_busy"},  32'(busy),         32'd0);
`ifdef DESKEW_SKEW_STAT_EN
        chk({tag, "_skew"},  32'(measured_skew), 32'(e.skew));
`endif
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic mk(input logic [LANES-1:0] m);
        marker = m;
        tick();
        marker = '0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        soft_rst  = 1'b0;
        en_ltssm  = 1'b1;
        gen       = 1'b1;
        start     = 1'b0;
        lane_mask = 4'hF;
        marker    = 4'h0;
        repeat (3) tick();
        chk("rst_delay", 32'(delay_select), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_done",  32'(done),  32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        tick();

        // All lanes aligned already.
        pulse_start();
        chk("armed_busy", 32'(busy), 32'd1);
        push(12'h000, 1'b1, 1'b0, 3'd0);
        mk(4'hF);
        wait_result("aligned", 0);

        // Staggered arrivals 0,2,5,1 with a repeat pulse on lane0 that must be ignored.
        pulse_start();
        mk(4'b0001);
        mk(4'b1000);
        mk(4'b0011);
        tick();
        tick();
        chk("stagger_pending_done", 32'(done), 32'd0);
        chk("stagger_pending_busy", 32'(busy), 32'd1);
        push({3'd4, 3'd0, 3'd3, 3'd5}, 1'b1, 1'b0, 3'd5);
        mk(4'b0100);
        wait_result("stagger", 0);

        // Largest legal skew: lane2 arrives six cycles late.
        pulse_start();
        mk(4'b1011);
        repeat (5) tick();
        push({3'd6, 3'd0, 3'd6, 3'd6}, 1'b1, 1'b0, 3'd6);
        mk(4'b0100);
        wait_result("maxskew", 0);

        // Lane2 never arrives: error once the counter passes MAX_SKEW, delays held.
        pulse_start();
        mk(4'b1011);
        repeat (5) tick();
        chk("overskew_early_error", 32'(error), 32'd0);
        push({3'd6, 3'd0, 3'd6, 3'd6}, 1'b0, 1'b1, 3'd6);
        wait_result("overskew", 1);

        // No marker at all: timeout error.
        pulse_start();
        repeat (200) tick();
        chk("timeout_early_error", 32'(error), 32'd0);
        chk("timeout_early_busy",  32'(busy),  32'd1);
        push({3'd6, 3'd0, 3'd6, 3'd6}, 1'b0, 1'b1, 3'd6);
        wait_result("timeout", 100);

        // Two-lane link; mask change after start and hits on unmasked lanes are ignored.
        lane_mask = 4'h3;
        pulse_start();
        lane_mask = 4'hF;
        mk(4'b0101);
        push(12'h001, 1'b1, 1'b0, 3'd1);
        mk(4'b1010);
        wait_result("mask3", 0);

        // EN_LTSSM dropped mid-MEASURE aborts to IDLE, delays held.
        pulse_start();
        mk(4'b0001);
        tick();
        en_ltssm = 1'b0;
        tick();
        chk("abort_busy",  32'(busy),  32'd0);
        chk("abort_done",  32'(done),  32'd0);
        chk("abort_error", 32'(error), 32'd0);
        chk("abort_delay", 32'(delay_select), 32'h001);
        en_ltssm = 1'b1;
        tick();

        // Empty mask locks immediately with zero delays.
        lane_mask = 4'h0;
        pulse_start();
        push(12'h000, 1'b1, 1'b0, 3'd0);
        wait_result("mask0", 1);

        // Async reset mid-MEASURE clears outputs without a clock edge.
        lane_mask = 4'h3;
        pulse_start();
        mk(4'b0001);
        push(12'h001, 1'b1, 1'b0, 3'd1);
        mk(4'b0010);
        wait_result("prerst", 0);
        pulse_start();
        mk(4'b0001);
        chk("prerst_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #2;
        chk("async_rst_delay", 32'(delay_select), 32'd0);
        chk("async_rst_busy",  32'(busy),  32'd0);
        chk("async_rst_done",  32'(done),  32'd0);
        chk("async_rst_error", 32'(error), 32'd0);
        rst = 1'b1;
        tick();

        // Synchronous soft reset from ARMED.
        lane_mask = 4'hF;
        pulse_start();
        chk("soft_pre_busy", 32'(busy), 32'd1);
        soft_rst = 1'b1;
        tick();
        soft_rst = 1'b0;
        chk("soft_busy", 32'(busy), 32'd0);
        chk("soft_done", 32'(done), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
